// File: rtl/hazard_pkg.sv
// Shared types for the D-stage hazard scoreboard: forward-select encoding,
// per-register scoreboard entry and a saturating decrement helper.
package hazard_pkg;

  // Forward source seen by the D stage; the value equals the writer's age.
  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_e;

  // Storage width of the remaining-cycles field; TNEW_W must not exceed it.
  localparam int unsigned HS_REMAIN_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [HS_REMAIN_W-1:0] remain;
    logic [1:0]             age;
  } hs_entry_t;

  function automatic logic [HS_REMAIN_W-1:0] sat_dec(input logic [HS_REMAIN_W-1:0] v);
    return (v == '0) ? '0 : v - HS_REMAIN_W'(1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request / hazard response bundle between decode and the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned TNEW_W   = 4
);
  localparam int unsigned RW = $clog2(NUM_REGS);

  logic              HS_i_Flush;
  logic              HS_i_D_Valid;
  logic [RW-1:0]     HS_i_D_Rs;
  logic [RW-1:0]     HS_i_D_Rt;
  logic [TNEW_W-1:0] HS_i_D_TuseRs;
  logic [TNEW_W-1:0] HS_i_D_TuseRt;
  logic [RW-1:0]     HS_i_D_WAddr;
  logic              HS_i_D_WEnable;
  logic [TNEW_W-1:0] HS_i_D_TnewD;
  logic              HS_i_D_MDUStart;
  logic              HS_i_D_MDUUse;
  logic              HS_o_Stall;
  logic [1:0]        HS_o_FwdD_Rs;
  logic [1:0]        HS_o_FwdD_Rt;
  logic              HS_o_MDUBusy;

  modport master (
    output HS_i_Flush, HS_i_D_Valid, HS_i_D_Rs, HS_i_D_Rt, HS_i_D_TuseRs,
           HS_i_D_TuseRt, HS_i_D_WAddr, HS_i_D_WEnable, HS_i_D_TnewD,
           HS_i_D_MDUStart, HS_i_D_MDUUse,
    input  HS_o_Stall, HS_o_FwdD_Rs, HS_o_FwdD_Rt, HS_o_MDUBusy
  );

  modport slave (
    input  HS_i_Flush, HS_i_D_Valid, HS_i_D_Rs, HS_i_D_Rt, HS_i_D_TuseRs,
           HS_i_D_TuseRt, HS_i_D_WAddr, HS_i_D_WEnable, HS_i_D_TnewD,
           HS_i_D_MDUStart, HS_i_D_MDUUse,
    output HS_o_Stall, HS_o_FwdD_Rs, HS_o_FwdD_Rt, HS_o_MDUBusy
  );
endinterface

// File: rtl/hs_mdu_counter.sv
// MDU busy counter: loads MDU_LAT when an MDU op issues, counts down to 0.
// Only instantiated when HS_MDU_TRACK_EN is defined.
module hs_mdu_counter #(
  parameter int unsigned MDU_LAT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic load_i,
  output logic busy_o
);
  localparam int unsigned CW = $clog2(MDU_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: flush wins over a new start, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)          cnt_d = '0;
    else if (load_i)      cnt_d = CW'(MDU_LAT);
    else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage RAW hazard scoreboard: tracks in-flight GPR writers by age and
// remaining latency, raises stall and selects forwarding sources.
// Optional MDU busy tracking is enabled by defining HS_MDU_TRACK_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned TNEW_W     = 4,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned MDU_LAT    = 5
) (
  input  logic                HS_i_Clk,
  input  logic                HS_i_Reset_n,
  hazard_scoreboard_if.slave  hs
);
  localparam int unsigned RW = $clog2(NUM_REGS);

  hs_entry_t entries_q [NUM_REGS];
  hs_entry_t entries_d [NUM_REGS];

  logic [RW-1:0]     rs, rt, waddr;
  logic [TNEW_W-1:0] tuse_rs, tuse_rt, tnew;
  logic              hit_rs, hit_rt, raw_stall, mdu_stall, stall, issue;

  assign rs      = hs.HS_i_D_Rs;
  assign rt      = hs.HS_i_D_Rt;
  assign waddr   = hs.HS_i_D_WAddr;
  assign tuse_rs = hs.HS_i_D_TuseRs;
  assign tuse_rt = hs.HS_i_D_TuseRt;
  assign tnew    = hs.HS_i_D_TnewD;

  // RAW check: a source stalls when its writer's result arrives after use.
  always_comb begin
    hit_rs    = (rs != '0) && entries_q[rs].valid &&
                (entries_q[rs].remain > HS_REMAIN_W'(tuse_rs));
    hit_rt    = (rt != '0) && entries_q[rt].valid &&
                (entries_q[rt].remain > HS_REMAIN_W'(tuse_rt));
    raw_stall = hs.HS_i_D_Valid && (hit_rs || hit_rt);
  end

`ifdef HS_MDU_TRACK_EN
  logic mdu_busy;

  hs_mdu_counter #(.MDU_LAT(MDU_LAT)) u_mdu_counter (
    .clk     (HS_i_Clk),
    .rst_n   (HS_i_Reset_n),
    .flush_i (hs.HS_i_Flush),
    .load_i  (issue && hs.HS_i_D_MDUStart),
    .busy_o  (mdu_busy)
  );

  assign mdu_stall       = hs.HS_i_D_Valid && (hs.HS_i_D_MDUUse || hs.HS_i_D_MDUStart) && mdu_busy;
  assign hs.HS_o_MDUBusy = mdu_busy;
`else
  logic unused_mdu;

  assign unused_mdu      = ^{hs.HS_i_D_MDUStart, hs.HS_i_D_MDUUse, 1'(MDU_LAT)};
  assign mdu_stall       = 1'b0;
  assign hs.HS_o_MDUBusy = 1'b0;
`endif

  assign stall = raw_stall || mdu_stall;
  assign issue = hs.HS_i_D_Valid && !stall;

  // Next scoreboard state: age every live writer, then overlay the newly
  // issued writer (which also replaces a same-register write-back), flush last.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      entries_d[r] = entries_q[r];
      if (entries_q[r].valid) begin
        if (entries_q[r].age == 2'(NUM_STAGES)) begin
          entries_d[r] = '0;
        end else begin
          entries_d[r].remain = sat_dec(entries_q[r].remain);
          entries_d[r].age    = entries_q[r].age + 2'd1;
        end
      end
    end
    if (issue && hs.HS_i_D_WEnable && (waddr != '0)) begin
      entries_d[waddr].valid  = 1'b1;
      entries_d[waddr].remain = sat_dec(HS_REMAIN_W'(tnew));
      entries_d[waddr].age    = 2'd1;
    end
    if (hs.HS_i_Flush) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) entries_d[r] = '0;
    end
    entries_d[0] = '0;
  end

  // Scoreboard register file.
  always_ff @(posedge HS_i_Clk or negedge HS_i_Reset_n) begin
    if (!HS_i_Reset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) entries_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) entries_q[r] <= entries_d[r];
    end
  end

  // Forward select: the writer's age names the stage holding the value.
  always_comb begin
    hs.HS_o_FwdD_Rs = 2'(FWD_GRF);
    hs.HS_o_FwdD_Rt = 2'(FWD_GRF);
    if ((rs != '0) && entries_q[rs].valid) hs.HS_o_FwdD_Rs = entries_q[rs].age;
    if ((rt != '0) && entries_q[rt].valid) hs.HS_o_FwdD_Rt = entries_q[rt].age;
  end

  assign hs.HS_o_Stall = stall;
endmodule
